// File: rtl/sync_sched_pkg.sv
// Shared types and field positions for the sync pulse scheduler.
package sync_sched_pkg;

  // Scheduler state; the encoding is visible to software in sync_status[1:0].
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_EXT = 2'd1,
    ST_RUN      = 2'd2,
    ST_DONE     = 2'd3
  } sched_state_e;

  // sync_ctrl bit positions
  localparam int unsigned CTRL_ENABLE   = 0;
  localparam int unsigned CTRL_ARM      = 1;
  localparam int unsigned CTRL_ONE_SHOT = 2;
  localparam int unsigned CTRL_USE_EXT  = 3;

  // sync_status field positions
  localparam int unsigned STAT_STATE_LSB  = 0;
  localparam int unsigned STAT_STATE_MSB  = 1;
  localparam int unsigned STAT_PERIOD_ERR = 2;

endpackage

// File: rtl/sync_pulse_scheduler_if.sv
// Register-side bundle of the sync pulse scheduler: software controls in,
// pulse and readback words out.
interface sync_pulse_scheduler_if #(
  parameter int unsigned CNT_W = 32
);
  logic [CNT_W-1:0] sync_period;
  logic [31:0]      sync_ctrl;
  logic             ext_sync;
  logic             sync_out;
  logic [CNT_W-1:0] sync_count;
  logic [31:0]      sync_status;

  // Register blocks / bench side
  modport master (
    output sync_period, sync_ctrl, ext_sync,
    input  sync_out, sync_count, sync_status
  );

  // Scheduler side
  modport slave (
    input  sync_period, sync_ctrl, ext_sync,
    output sync_out, sync_count, sync_status
  );
endinterface

// File: rtl/sync_period_counter.sv
// Period counter with shadowed, clamped period. Exposes the next counter
// value's pulse flag so the parent can register sync_out without extra lag.
module sync_period_counter
  import sync_sched_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned SYNC_LEN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] sync_period,
  input  logic             load,
  input  logic             clear,
  input  logic             run,
  output logic             wrap,
  output logic             last_pulse,
  output logic             clamp_err,
  output logic             pulse_active_next
);

  localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(SYNC_LEN + 1);
  localparam logic [CNT_W-1:0] PULSE_LEN  = CNT_W'(SYNC_LEN);
  localparam logic [CNT_W-1:0] LAST_PULSE = CNT_W'(SYNC_LEN - 1);

  logic [CNT_W-1:0] shadow;
  logic [CNT_W-1:0] shadow_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] eff_period;

  assign clamp_err  = (sync_period < MIN_PERIOD);
  assign eff_period = clamp_err ? MIN_PERIOD : sync_period;
  assign wrap       = (cnt == shadow - 1'b1);
  assign last_pulse = (cnt == LAST_PULSE);

  // Next counter and shadow: load restarts with a fresh period, wrap reloads it
  always_comb begin
    cnt_next    = cnt;
    shadow_next = shadow;
    if (load) begin
      cnt_next    = '0;
      shadow_next = eff_period;
    end else if (clear) begin
      cnt_next = '0;
    end else if (run) begin
      if (wrap) begin
        cnt_next    = '0;
        shadow_next = eff_period;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end
  end

  assign pulse_active_next = (cnt_next < PULSE_LEN);

  // Counter and shadow registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      shadow <= MIN_PERIOD;
    end else begin
      cnt    <= cnt_next;
      shadow <= shadow_next;
    end
  end

endmodule

// File: rtl/sync_pulse_scheduler.sv
// Sync pulse scheduler: arm/trigger FSM, pulse count and status readback
// around a shadowed period counter.
module sync_pulse_scheduler
  import sync_sched_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned SYNC_LEN = 1
) (
  input  logic                   user_clk,
  input  logic                   user_rst_n,
  sync_pulse_scheduler_if.slave  bus
);

  sched_state_e state;
  sched_state_e state_next;

  logic enable;
  logic arm;
  logic one_shot;
  logic use_ext;
  logic arm_q;
  logic arm_ev;
  logic one_shot_q;

  logic cnt_load;
  logic cnt_clear;
  logic cnt_run;
  logic wrap;
  logic last_pulse;
  logic clamp_err;
  logic pulse_active_next;
  logic pulse_start;
  logic sync_out_d;

  logic             sync_out_q;
  logic [CNT_W-1:0] sync_count_q;
  logic             period_err_q;
  logic [27:0]      ctrl_unused;

  assign enable      = bus.sync_ctrl[CTRL_ENABLE];
  assign arm         = bus.sync_ctrl[CTRL_ARM];
  assign one_shot    = bus.sync_ctrl[CTRL_ONE_SHOT];
  assign use_ext     = bus.sync_ctrl[CTRL_USE_EXT];
  assign ctrl_unused = bus.sync_ctrl[31:4];
  assign arm_ev      = enable & arm & ~arm_q;

  sync_period_counter #(
    .CNT_W    (CNT_W),
    .SYNC_LEN (SYNC_LEN)
  ) u_period_counter (
    .clk               (user_clk),
    .rst_n             (user_rst_n),
    .sync_period       (bus.sync_period),
    .load              (cnt_load),
    .clear             (cnt_clear),
    .run               (cnt_run),
    .wrap              (wrap),
    .last_pulse        (last_pulse),
    .clamp_err         (clamp_err),
    .pulse_active_next (pulse_active_next)
  );

  // State register
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) state <= ST_IDLE;
    else             state <= state_next;
  end

  // Next state: arm event beats everything, then disable, then per-state moves
  always_comb begin
    state_next = state;
    if (arm_ev) begin
      state_next = use_ext ? ST_WAIT_EXT : ST_RUN;
    end else if (!enable) begin
      state_next = ST_IDLE;
    end else begin
      unique case (state)
        ST_WAIT_EXT: if (bus.ext_sync) state_next = ST_RUN;
        ST_RUN:      if (one_shot_q && last_pulse) state_next = ST_DONE;
        default:     state_next = state;
      endcase
    end
  end

  // Counter controls and next registered outputs
  always_comb begin
    cnt_load  = arm_ev;
    cnt_clear = !arm_ev && (!enable || state == ST_IDLE || state == ST_WAIT_EXT);
    cnt_run   = !arm_ev && enable && state == ST_RUN && !(one_shot_q && last_pulse);
    // A pulse starts whenever RUN is entered, or on a wrap while staying in RUN
    pulse_start = (state_next == ST_RUN) && (arm_ev || state != ST_RUN || wrap);
    sync_out_d  = (state_next == ST_RUN) && pulse_active_next;
  end

  // Arm edge history, one-shot latch, pulse output, count and sticky error
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      arm_q        <= 1'b0;
      one_shot_q   <= 1'b0;
      sync_out_q   <= 1'b0;
      sync_count_q <= '0;
      period_err_q <= 1'b0;
    end else begin
      arm_q      <= arm;
      sync_out_q <= sync_out_d;
      if (arm_ev) begin
        one_shot_q   <= one_shot;
        period_err_q <= clamp_err;
        sync_count_q <= pulse_start ? CNT_W'(1) : '0;
      end else begin
        if (cnt_run && wrap && clamp_err) period_err_q <= 1'b1;
        if (pulse_start && sync_count_q != '1) sync_count_q <= sync_count_q + 1'b1;
      end
    end
  end

  // Readback
  always_comb begin
    bus.sync_status = '0;
    bus.sync_status[STAT_STATE_MSB:STAT_STATE_LSB] = state;
    bus.sync_status[STAT_PERIOD_ERR] = period_err_q;
  end

  assign bus.sync_out   = sync_out_q;
  assign bus.sync_count = sync_count_q;

endmodule

// File: tb/tb_sync_pulse_scheduler.sv
// Directed bench for sync_pulse_scheduler with SYNC_LEN of 1, 3 and 4.
module tb_sync_pulse_scheduler;

  localparam logic [31:0] EN  = 32'h1;
  localparam logic [31:0] ARM = 32'h2;
  localparam logic [31:0] OS  = 32'h4;
  localparam logic [31:0] UX  = 32'h8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sync_pulse_scheduler_if #(.CNT_W(32)) if1 ();
  sync_pulse_scheduler_if #(.CNT_W(32)) if3 ();
  sync_pulse_scheduler_if #(.CNT_W(32)) if4 ();

  sync_pulse_scheduler #(.CNT_W(32), .SYNC_LEN(1)) dut1 (.user_clk(clk), .user_rst_n(rst_n), .bus(if1));
  sync_pulse_scheduler #(.CNT_W(32), .SYNC_LEN(3)) dut3 (.user_clk(clk), .user_rst_n(rst_n), .bus(if3));
  sync_pulse_scheduler #(.CNT_W(32), .SYNC_LEN(4)) dut4 (.user_clk(clk), .user_rst_n(rst_n), .bus(if4));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    if1.sync_period = 32'd10; if1.sync_ctrl = '0; if1.ext_sync = 1'b0;
    if3.sync_period = 32'd10; if3.sync_ctrl = '0; if3.ext_sync = 1'b0;
    if4.sync_period = 32'd10; if4.sync_ctrl = '0; if4.ext_sync = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (if1.sync_out !== 1'b0) begin errors++; $display("FAIL reset_out got %0b exp 0", if1.sync_out); end
    checks++; if (if1.sync_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", if1.sync_count); end
    checks++; if (if1.sync_status !== 32'd0) begin errors++; $display("FAIL reset_status got %0h exp 0", if1.sync_status); end
    checks++; if (if3.sync_status !== 32'd0) begin errors++; $display("FAIL reset_status3 got %0h exp 0", if3.sync_status); end
    rst_n = 1'b1;
    repeat (2) tick();
    checks++; if (if1.sync_status !== 32'd0 || if1.sync_out !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle got status %0h out %0b exp 0 0", if1.sync_status, if1.sync_out); end
  endtask

  task automatic test_periodic;
    logic exp;
    if1.sync_period = 32'd10;
    if1.sync_ctrl = EN | ARM;
    tick();
    checks++; if (if1.sync_status !== 32'd2) begin errors++; $display("FAIL periodic_state got %0h exp 2", if1.sync_status); end
    for (int i = 0; i <= 20; i++) begin
      exp = (i % 10 == 0);
      checks++; if (if1.sync_out !== exp) begin errors++; $display("FAIL periodic_out i=%0d got %0b exp %0b", i, if1.sync_out, exp); end
      if (i < 20) tick();
    end
    checks++; if (if1.sync_count !== 32'd3) begin errors++; $display("FAIL periodic_count got %0d exp 3", if1.sync_count); end
    if1.sync_ctrl = '0;
    tick();
    checks++; if (if1.sync_status !== 32'd0 || if1.sync_count !== 32'd3) begin
      errors++; $display("FAIL disable_hold got status %0h count %0d exp 0 3", if1.sync_status, if1.sync_count); end
  endtask

  task automatic test_clamp;
    logic exp;
    if3.sync_period = 32'd2;
    if3.sync_ctrl = EN | ARM;
    tick();
    for (int i = 0; i < 12; i++) begin
      exp = (i % 4 < 3);
      checks++; if (if3.sync_out !== exp) begin errors++; $display("FAIL clamp_out i=%0d got %0b exp %0b", i, if3.sync_out, exp); end
      if (i < 11) tick();
    end
    checks++; if (if3.sync_status !== 32'h6) begin errors++; $display("FAIL clamp_status got %0h exp 6", if3.sync_status); end
    checks++; if (if3.sync_count !== 32'd3) begin errors++; $display("FAIL clamp_count got %0d exp 3", if3.sync_count); end
    if3.sync_ctrl = '0;
    tick();
  endtask

  task automatic test_one_shot_ext;
    if1.sync_period = 32'd10;
    if1.sync_ctrl = EN | ARM | OS | UX;
    tick();
    checks++; if (if1.sync_status !== 32'd1) begin errors++; $display("FAIL oneshot_wait got %0h exp 1", if1.sync_status); end
    checks++; if (if1.sync_count !== 32'd0) begin errors++; $display("FAIL oneshot_arm_count got %0d exp 0", if1.sync_count); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (if1.sync_out !== 1'b0) begin errors++; $display("FAIL oneshot_idle_out i=%0d got %0b exp 0", i, if1.sync_out); end
    end
    if1.ext_sync = 1'b1;
    tick();
    if1.ext_sync = 1'b0;
    checks++; if (if1.sync_out !== 1'b1 || if1.sync_count !== 32'd1 || if1.sync_status !== 32'd2) begin
      errors++; $display("FAIL oneshot_pulse got out %0b count %0d status %0h exp 1 1 2", if1.sync_out, if1.sync_count, if1.sync_status); end
    tick();
    checks++; if (if1.sync_status !== 32'd3 || if1.sync_out !== 1'b0) begin
      errors++; $display("FAIL oneshot_done got status %0h out %0b exp 3 0", if1.sync_status, if1.sync_out); end
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++; if (if1.sync_out !== 1'b0) begin errors++; $display("FAIL oneshot_quiet i=%0d got %0b exp 0", i, if1.sync_out); end
    end
    checks++; if (if1.sync_count !== 32'd1 || if1.sync_status !== 32'd3) begin
      errors++; $display("FAIL oneshot_hold got count %0d status %0h exp 1 3", if1.sync_count, if1.sync_status); end
    if1.sync_ctrl = '0;
    tick();
  endtask

  task automatic test_arm_vs_ext;
    if1.sync_ctrl = EN | ARM | UX;
    tick();
    if1.sync_ctrl = EN | UX;
    tick();
    checks++; if (if1.sync_status !== 32'd1) begin errors++; $display("FAIL armext_wait got %0h exp 1", if1.sync_status); end
    if1.sync_ctrl = EN | ARM | UX;
    if1.ext_sync = 1'b1;
    tick();
    if1.ext_sync = 1'b0;
    checks++; if (if1.sync_status !== 32'd1 || if1.sync_out !== 1'b0) begin
      errors++; $display("FAIL armext_wins got status %0h out %0b exp 1 0", if1.sync_status, if1.sync_out); end
    if1.sync_ctrl = '0;
    tick();
  endtask

  task automatic test_period_change;
    logic exp;
    if1.sync_period = 32'd10;
    if1.sync_ctrl = EN | ARM;
    tick();
    checks++; if (if1.sync_out !== 1'b1) begin errors++; $display("FAIL pchg_first got %0b exp 1", if1.sync_out); end
    for (int i = 1; i <= 31; i++) begin
      tick();
      if (i == 3) if1.sync_period = 32'd20;
      exp = (i == 10 || i == 30);
      checks++; if (if1.sync_out !== exp) begin errors++; $display("FAIL pchg_out i=%0d got %0b exp %0b", i, if1.sync_out, exp); end
    end
    checks++; if (if1.sync_count !== 32'd3) begin errors++; $display("FAIL pchg_count got %0d exp 3", if1.sync_count); end
    if1.sync_ctrl = '0;
    if1.sync_period = 32'd10;
    tick();
  endtask

  task automatic test_disable_mid_pulse;
    logic exp;
    if4.sync_period = 32'd10;
    if4.sync_ctrl = EN | ARM;
    tick();
    tick();
    checks++; if (if4.sync_out !== 1'b1 || if4.sync_count !== 32'd1) begin
      errors++; $display("FAIL dis_pulse got out %0b count %0d exp 1 1", if4.sync_out, if4.sync_count); end
    if4.sync_ctrl = '0;
    tick();
    checks++; if (if4.sync_out !== 1'b0 || if4.sync_status !== 32'd0 || if4.sync_count !== 32'd1) begin
      errors++; $display("FAIL dis_stop got out %0b status %0h count %0d exp 0 0 1", if4.sync_out, if4.sync_status, if4.sync_count); end
    if4.sync_ctrl = EN;
    tick();
    if4.sync_ctrl = EN | ARM;
    tick();
    checks++; if (if4.sync_out !== 1'b1 || if4.sync_count !== 32'd1 || if4.sync_status !== 32'd2) begin
      errors++; $display("FAIL dis_rearm got out %0b count %0d status %0h exp 1 1 2", if4.sync_out, if4.sync_count, if4.sync_status); end
    for (int i = 1; i <= 5; i++) begin
      tick();
      exp = (i < 4);
      checks++; if (if4.sync_out !== exp) begin errors++; $display("FAIL dis_width i=%0d got %0b exp %0b", i, if4.sync_out, exp); end
    end
    if4.sync_ctrl = '0;
    tick();
  endtask

  task automatic test_reset_mid_run;
    if4.sync_period = 32'd10;
    if4.sync_ctrl = EN | ARM;
    tick();
    tick();
    checks++; if (if4.sync_out !== 1'b1) begin errors++; $display("FAIL rst_pre got %0b exp 1", if4.sync_out); end
    rst_n = 1'b0;
    #1;
    checks++; if (if4.sync_out !== 1'b0 || if4.sync_count !== 32'd0 || if4.sync_status !== 32'd0) begin
      errors++; $display("FAIL rst_async got out %0b count %0d status %0h exp 0 0 0", if4.sync_out, if4.sync_count, if4.sync_status); end
    if4.sync_ctrl = EN;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      checks++; if (if4.sync_out !== 1'b0 || if4.sync_status !== 32'd0) begin
        errors++; $display("FAIL rst_quiet i=%0d got out %0b status %0h exp 0 0", i, if4.sync_out, if4.sync_status); end
    end
    if4.sync_ctrl = EN | ARM;
    tick();
    checks++; if (if4.sync_out !== 1'b1 || if4.sync_count !== 32'd1) begin
      errors++; $display("FAIL rst_rearm got out %0b count %0d exp 1 1", if4.sync_out, if4.sync_count); end
    if4.sync_ctrl = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_clamp();
    test_one_shot_ext();
    test_arm_vs_ext();
    test_period_change();
    test_disable_mid_pulse();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_pulse_scheduler.md
# sync_pulse_scheduler

Sequences the periodic sync pulse for the testing sync generator in the `user_clk` domain. It consumes the `sync_period` value and a control word, both driven by software-register blocks on the OPB bus. It arms, optionally waits for an external trigger, and emits fixed-width sync pulses every `sync_period` cycles, in periodic or one-shot mode. A pulse count and state/status word are returned to software through a readback register.

## Interface
- `CNT_W`, 32: width of period counter, `sync_period`, `sync_count`
- `SYNC_LEN`, 1: sync pulse width in cycles, ≥1
- `user_clk`  in  1: sole clock.
- `user_rst_n`  in  1: reset, asynchronous assert, active-low.
- `sync_period`  in  CNT_W: cycles between pulse starts, from software register.
- `sync_ctrl`  in  32: bit0 `enable` (level), bit1 `arm` (rising edge acts), bit2 `one_shot`, bit3 `use_ext`; other bits ignored.
- `ext_sync`  in  1: external trigger, already synchronous to `user_clk`.
- `sync_out`  out  1: sync pulse.
- `sync_count`  out  CNT_W: pulses started since last arm, saturating.
- `sync_status`  out  32: [1:0] state code, bit2 `period_err` (sticky), [31:3] zero.

## Operation
- States and codes: IDLE=0, WAIT_EXT=1, RUN=2, DONE=3.
- Arm event: `arm` is 1 this cycle and was 0 last cycle, with `enable`=1. The previous value of `arm` is registered.
- Effective period `P`:
  - `P` = `sync_period` if `sync_period` ≥ SYNC_LEN+1.
  - Otherwise `P` = SYNC_LEN+1, and `period_err` is set.
  - `P` is latched into a shadow register on an arm event and at each counter wrap only. Mid-period writes take effect at the next wrap.
- IDLE:
  - Counter = 0, `sync_out` = 0.
  - On arm event: latch `P`, clear `sync_count`, clear `period_err` (it is then re-evaluated).
  - Next state is WAIT_EXT if `use_ext`, else RUN.
- WAIT_EXT: when `ext_sync`=1, go to RUN.
- RUN:
  - Counter counts 0..P-1, then wraps to 0 and reloads the shadow.
  - `sync_out`=1 while counter < SYNC_LEN.
  - `sync_count` increments when counter = 0, saturating at all-ones.
  - If `one_shot`=1 (sampled at arm), go to DONE when counter reaches SYNC_LEN-1.
- DONE: `sync_out`=0; counter and `sync_count` hold.
- An arm event in WAIT_EXT, RUN or DONE restarts exactly as from IDLE. A pulse in progress is truncated.
- `enable`=0 in any state:
  - Next state is IDLE and `sync_out` goes to 0.
  - `sync_count` and `period_err` hold for readback.
  - An arm event has priority over `enable`=0 only if `enable`=1 in the same cycle (by definition).
- Simultaneous `ext_sync` and arm event in WAIT_EXT: the arm event wins, and the block stays in or re-enters WAIT_EXT.

## Timing
- All outputs are registered.
- Reset values: `sync_out`=0, `sync_count`=0, `sync_status`=0, state IDLE, counter 0, shadow = SYNC_LEN+1.
- Arm event sampled at cycle t with `use_ext`=0: state=RUN and `sync_out`=1 at t+1. Later pulse starts at t+1+kP.
- `ext_sync` sampled high at cycle e in WAIT_EXT: first pulse at e+1.
- `sync_count` updates in the same cycle the pulse starts.
- Status reflects the state as registered; its readback latency is one cycle.
- Reset assertion mid-pulse drops `sync_out` asynchronously. Release is synchronous to `user_clk`; the integration level handles that.

## Structure
- Package `sync_sched_pkg`: state enum and codes, `sync_ctrl` bit indices, `sync_status` field positions.
- Sub-module `sync_period_counter`:
  - Contents: shadow register, clamp, counter, wrap and `pulse_active` flags.
  - Controls: `load`, `clear`, `run`.
- FSM, arm edge detect and `sync_count` live in the top module.

## Test plan
- Periodic: `sync_period`=10, `enable`/`arm` rise at cycle 5 → `sync_out` high at cycles 6, 16, 26…; `sync_count`=3 at cycle 26.
- SYNC_LEN=3, `sync_period`=2 → clamped to P=4; `period_err`=1; `sync_out` high 3 of every 4 cycles.
- One-shot with `use_ext`: arm, state=1, `ext_sync` pulse at cycle 40 → single pulse at 41; state=3; `sync_count`=1.
- Period change mid-RUN: P=10 running, write 20 at counter=3 → next pulse 10 cycles after the previous one, then spacing 20.
- Disable mid-pulse (SYNC_LEN=4): `enable`=0 at pulse cycle 2 → `sync_out`=0 next cycle; state=0; `sync_count` held. Re-arm restarts with `sync_count`=0→1.
- Reset asserted while in RUN → all outputs 0 immediately; after release no pulse until a new arm event.
